// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding imem request feeding a
// small in-order queue toward decode, with flush and late-response drop.
module ifetch_queue #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_advance,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t          r_state;
   logic [31:0]     r_pend_pc;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_rptr;
   logic [AW-1:0]   r_wptr;
   logic [31:0]     r_q_pc    [DEPTH];
   logic [31:0]     r_q_instr [DEPTH];

   logic            w_busy;
   logic [CW-1:0]   w_occ;
   logic            w_push;
   logic            w_pop;
   logic [1:0]      w_unused_pc;

   assign w_unused_pc = pc_in[1:0];

   // An outstanding request already owns a queue slot
   assign w_busy = (r_state != IDLE);
   assign w_occ  = r_count + CW'(w_busy);

   assign imem_addr  = {pc_in[31:2], 2'b00};
   assign imem_req   = !rst && (r_state == IDLE) && !flush
                       && (w_occ < C_DEPTH);
   assign pc_advance = imem_req & imem_gnt;

   assign w_push = (r_state == WAIT) && imem_rvalid && !flush;
   assign w_pop  = id_valid && id_ready && !flush;

   assign id_valid = (r_count != '0);
   assign id_pc    = r_q_pc[r_rptr];
   assign id_instr = r_q_instr[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pend_pc <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (pc_advance) begin
                  r_pend_pc <= imem_addr;
                  r_state   <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rvalid)
                  r_state <= IDLE;
               else if (flush)
                  r_state <= DROP;
            end
            DROP: begin
               if (imem_rvalid)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]    <= '0;
            r_q_instr[i] <= '0;
         end
      end else if (flush) begin
         r_count <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
      end else begin
         if (w_push) begin
            r_q_pc[r_wptr]    <= r_pend_pc;
            r_q_instr[r_wptr] <= imem_rdata;
            r_wptr            <= r_wptr + 1'b1;
         end
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (!w_push && w_pop)
            r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: inputs change and outputs are
// checked on the falling edge; state commits on the rising edge.
module tb_ifetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_advance;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;

   int n_checks;
   int n_errors;

   ifetch_queue #(.DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .pc_advance  (pc_advance),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_instr    (id_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      flush       = 1'b0;
      pc_in       = 32'h0;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;

      // Reset state
      @(negedge clk); #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_adv", {31'd0, pc_advance}, 32'd0);
      chk("rst_vld", {31'd0, id_valid}, 32'd0);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_ins", id_instr, 32'h0);

      // Basic fetch
      @(negedge clk);
      rst = 1'b0; id_ready = 1'b1; #1;
      chk("bf_req", {31'd0, imem_req}, 32'd1);
      chk("bf_addr", imem_addr, 32'h0);
      chk("bf_adv", {31'd0, pc_advance}, 32'd1);
      @(negedge clk);
      pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h20080005; #1;
      chk("bf_wait_req", {31'd0, imem_req}, 32'd0);
      chk("bf_one_adv", {31'd0, pc_advance}, 32'd0);
      chk("bf_nobypass", {31'd0, id_valid}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; imem_gnt = 1'b0; #1;
      chk("bf_vld", {31'd0, id_valid}, 32'd1);
      chk("bf_pc", id_pc, 32'h0);
      chk("bf_ins", id_instr, 32'h20080005);
      @(negedge clk); #1;
      chk("bf_popped", {31'd0, id_valid}, 32'd0);

      // Backpressure fills both slots, then drains in order
      id_ready = 1'b0; imem_gnt = 1'b1; pc_in = 32'h0; #1;
      chk("bp_req0", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'hA0000000; #1;
      chk("bp_wait0", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("bp_req1", {31'd0, imem_req}, 32'd1);
      chk("bp_addr1", imem_addr, 32'h4);
      chk("bp_pc_a", id_pc, 32'h0);
      @(negedge clk);
      pc_in = 32'h8; imem_rvalid = 1'b1; imem_rdata = 32'hA0000004; #1;
      chk("bp_wait1", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("bp_full_req", {31'd0, imem_req}, 32'd0);
      chk("bp_hold_pc", id_pc, 32'h0);
      @(negedge clk); #1;
      chk("bp_full_req2", {31'd0, imem_req}, 32'd0);
      chk("bp_hold_pc2", id_pc, 32'h0);
      chk("bp_hold_ins", id_instr, 32'hA0000000);
      imem_gnt = 1'b0; id_ready = 1'b1;
      @(negedge clk); #1;
      chk("bp_pc_b", id_pc, 32'h4);
      chk("bp_ins_b", id_instr, 32'hA0000004);
      chk("bp_vld_b", {31'd0, id_valid}, 32'd1);
      @(negedge clk); #1;
      chk("bp_empty", {31'd0, id_valid}, 32'd0);
      id_ready = 1'b0;

      // Flush while waiting: response is dropped
      pc_in = 32'h20; imem_gnt = 1'b1; #1;
      chk("fw_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      imem_gnt = 1'b0; flush = 1'b1; #1;
      chk("fw_flush_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      flush = 1'b0; pc_in = 32'h40; imem_gnt = 1'b1; #1;
      chk("fw_drop_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; #1;
      chk("fw_drop_req2", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("fw_no_push", {31'd0, id_valid}, 32'd0);
      chk("fw_req40", {31'd0, imem_req}, 32'd1);
      chk("fw_addr40", imem_addr, 32'h40);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB0000040;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("fw_vld", {31'd0, id_valid}, 32'd1);
      chk("fw_pc", id_pc, 32'h40);
      chk("fw_ins", id_instr, 32'hB0000040);

      // Flush with rvalid in the same cycle, queue at capacity
      pc_in = 32'h44; imem_gnt = 1'b1; #1;
      chk("fr_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1;
      imem_rdata = 32'hC0000044; id_ready = 1'b1; #1;
      chk("fr_flush_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      flush = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0; #1;
      chk("fr_empty", {31'd0, id_valid}, 32'd0);
      chk("fr_idle_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk); #1;
      chk("fr_still_empty", {31'd0, id_valid}, 32'd0);

      // Misaligned pc_in
      pc_in = 32'h13; imem_gnt = 1'b1; #1;
      chk("ma_addr", imem_addr, 32'h10);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hD0000010;
      @(negedge clk);
      imem_rvalid = 1'b0; id_ready = 1'b1; #1;
      chk("ma_pc", id_pc, 32'h10);
      chk("ma_ins", id_instr, 32'hD0000010);
      @(negedge clk);
      id_ready = 1'b0;

      // Response while idle is ignored
      imem_rvalid = 1'b1; imem_rdata = 32'hEEEEEEEE;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("idle_rvalid", {31'd0, id_valid}, 32'd0);

      // Async reset mid-WAIT with one entry queued
      pc_in = 32'h60; imem_gnt = 1'b1;
      @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = 32'hF0000060; imem_gnt = 1'b0;
      @(negedge clk);
      imem_rvalid = 1'b0; pc_in = 32'h64; imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b1; #1;
      chk("ar_pre_vld", {31'd0, id_valid}, 32'd1);
      chk("ar_pre_req", {31'd0, imem_req}, 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("ar_vld", {31'd0, id_valid}, 32'd0);
      chk("ar_req", {31'd0, imem_req}, 32'd0);
      chk("ar_adv", {31'd0, pc_advance}, 32'd0);
      chk("ar_pc", id_pc, 32'h0);
      chk("ar_ins", id_instr, 32'h0);
      imem_rvalid = 1'b1; imem_rdata = 32'h99999999;
      @(negedge clk);
      rst = 1'b0; imem_gnt = 1'b0; pc_in = 32'h100; #1;
      chk("ar_restart_req", {31'd0, imem_req}, 32'd1);
      chk("ar_restart_addr", imem_addr, 32'h100);
      @(negedge clk);
      imem_rvalid = 1'b0; imem_gnt = 1'b1; #1;
      chk("ar_late_drop", {31'd0, id_valid}, 32'd0);
      chk("ar_adv2", {31'd0, pc_advance}, 32'd1);
      @(negedge clk);
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
      @(negedge clk);
      imem_rvalid = 1'b0; #1;
      chk("ar_new_pc", id_pc, 32'h100);
      chk("ar_new_ins", id_instr, 32'h12345678);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
